// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one sram_driver between a command port (A) and a scan port (B).
// Each access: latch request, pulse start, wait for ready to fall then rise, ack the winner.
module sram_arbiter #(
   parameter int ADDR_W  = 13,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_re,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_re,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   input  logic              drv_ready,
   output logic              drv_start,
   output logic              drv_re,
   output logic [ADDR_W-1:0] drv_address,
   output logic [DATA_W-1:0] drv_data_write,
   input  logic [DATA_W-1:0] drv_data_read,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, ABORT} state_t;

   localparam logic       PORT_A      = 1'b0;
   localparam logic       PORT_B      = 1'b1;
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t              state_reg, state_next;
   logic                grant_reg, grant_next;
   logic                last_reg, last_next;
   logic [7:0]          cnt_reg, cnt_next;
   logic                re_reg, re_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   wdata_reg, wdata_next;
   logic [DATA_W-1:0]   a_rdata_reg, a_rdata_next;
   logic [DATA_W-1:0]   b_rdata_reg, b_rdata_next;
   logic                err_reg, err_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         grant_reg   <= PORT_A;
         last_reg    <= PORT_B;
         cnt_reg     <= '0;
         re_reg      <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         a_rdata_reg <= '0;
         b_rdata_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         grant_reg   <= grant_next;
         last_reg    <= last_next;
         cnt_reg     <= cnt_next;
         re_reg      <= re_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         a_rdata_reg <= a_rdata_next;
         b_rdata_reg <= b_rdata_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      grant_next   = grant_reg;
      last_next    = last_reg;
      cnt_next     = cnt_reg;
      re_next      = re_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      a_rdata_next = a_rdata_reg;
      b_rdata_next = b_rdata_reg;
      err_next     = err_reg;
      drv_start    = 1'b0;
      a_ack        = 1'b0;
      b_ack        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (drv_ready && (a_req || b_req)) begin
               // On a tie the port that did not go last wins; otherwise the lone requester.
               grant_next = (a_req && b_req) ? ~last_reg : b_req;
               if (grant_next == PORT_B) begin
                  re_next    = b_re;
                  addr_next  = b_addr;
                  wdata_next = b_wdata;
               end else begin
                  re_next    = a_re;
                  addr_next  = a_addr;
                  wdata_next = a_wdata;
               end
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            drv_start  = 1'b1;
            cnt_next   = '0;
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!drv_ready) begin
               cnt_next   = '0;
               state_next = WAIT_DONE;
            end else if (cnt_reg == TIMEOUT_CNT) begin
               state_next = ABORT;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         WAIT_DONE: begin
            if (drv_ready) begin
               if (re_reg) begin
                  if (grant_reg == PORT_B) b_rdata_next = drv_data_read;
                  else                     a_rdata_next = drv_data_read;
               end
               state_next = RESP;
            end else if (cnt_reg == TIMEOUT_CNT) begin
               state_next = ABORT;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         RESP: begin
            a_ack      = (grant_reg == PORT_A);
            b_ack      = (grant_reg == PORT_B);
            last_next  = grant_reg;
            state_next = IDLE;
         end
         ABORT: begin
            a_ack      = (grant_reg == PORT_A);
            b_ack      = (grant_reg == PORT_B);
            err_next   = 1'b1;
            last_next  = grant_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy           = (state_reg != IDLE);
   assign drv_re         = re_reg;
   assign drv_address    = addr_reg;
   assign drv_data_write = wdata_reg;
   assign a_rdata        = a_rdata_reg;
   assign b_rdata        = b_rdata_reg;
   assign timeout_err    = err_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter with a behavioural sram_driver model.
// The monitor predicts each grant from the round-robin rule and a reference memory.
module tb_sram_arbiter;

   localparam int ADDR_W  = 13;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 255;

   logic              clk = 1'b0;
   logic              reset;
   logic              a_req, a_re, b_req, b_re;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [DATA_W-1:0] a_wdata, b_wdata;
   logic              a_ack, b_ack;
   logic [DATA_W-1:0] a_rdata, b_rdata;
   logic              drv_ready, drv_start, drv_re;
   logic [ADDR_W-1:0] drv_address;
   logic [DATA_W-1:0] drv_data_write, drv_data_read;
   logic              busy, timeout_err;

   sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_re(a_re), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_re(b_re), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
      .drv_ready(drv_ready), .drv_start(drv_start), .drv_re(drv_re), .drv_address(drv_address),
      .drv_data_write(drv_data_write), .drv_data_read(drv_data_read),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic re; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } txn_t;

   int   compared   = 0;
   int   mismatched = 0;
   int   lat_cfg    = 10;
   bit   stuck      = 1'b0;
   txn_t q_a[$];
   txn_t q_b[$];
   bit   ack_log[$];

   function automatic logic [DATA_W-1:0] mem_init(input logic [ADDR_W-1:0] a);
      if (a == 13'h1FFF) return 8'hC3;
      return 8'(a * 7 + 3);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural sram_driver: ready drops the cycle after start, rises lat_cfg+1 cycles later.
   logic              m_ready, m_busy, m_re;
   int                m_cnt;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_rdata;
   logic [DATA_W-1:0] dmem [8192];
   bit                written [8192];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ready <= 1'b1;
         m_busy  <= 1'b0;
         m_cnt   <= 0;
      end else if (m_busy) begin
         if (m_cnt == 0) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
            if (m_re) m_rdata <= written[m_addr] ? dmem[m_addr] : mem_init(m_addr);
            else begin
               dmem[m_addr]    <= m_wdata;
               written[m_addr] <= 1'b1;
            end
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (drv_start && !stuck) begin
         m_busy  <= 1'b1;
         m_ready <= 1'b0;
         m_cnt   <= lat_cfg;
         m_re    <= drv_re;
         m_addr  <= drv_address;
         m_wdata <= drv_data_write;
      end
   end
   assign drv_ready     = m_ready;
   assign drv_data_read = m_rdata;

   // Monitor / reference model state
   logic [DATA_W-1:0] ref_mem [int];
   bit                ref_last, ref_err, in_flight, exp_port, cur_abort;
   bit                prev_a, prev_b, prev_start;
   logic [DATA_W-1:0] ref_a_rdata, ref_b_rdata, exp_rdata;
   txn_t              cur;
   int                cyc = 0, start_cyc = 0, txn_no = 0;

   function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_init(a);
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            q_a.delete(); q_b.delete();
            in_flight = 0; ref_last = 1; ref_err = 0;
            ref_a_rdata = '0; ref_b_rdata = '0;
            prev_a = 0; prev_b = 0; prev_start = 0;
         end else begin
            check("timeout_err", 64'(timeout_err), 64'(ref_err));
            if (drv_start) begin
               check("start_width", 64'(prev_start), 64'd0);
               check("start_has_req", 64'(prev_a | prev_b), 64'd1);
               check("start_while_idle", 64'(in_flight), 64'd0);
               exp_port = (prev_a && prev_b) ? !ref_last : prev_b;
               if ((exp_port ? q_b.size() : q_a.size()) == 0) begin
                  check("grant_port_queue", 64'd0, 64'd1);
               end else begin
                  cur       = exp_port ? q_b.pop_front() : q_a.pop_front();
                  in_flight = 1;
                  start_cyc = cyc;
                  cur_abort = stuck;
                  if (!stuck) begin
                     if (cur.re) exp_rdata = ref_rd(cur.addr);
                     else        ref_mem[int'(cur.addr)] = cur.wdata;
                  end
               end
            end
            if (in_flight && busy)
               check("drv_hold", {42'd0, drv_re, drv_address, drv_data_write}, {42'd0, cur.re, cur.addr, cur.wdata});
            if (a_ack || b_ack) begin
               check("ack_expected", 64'(in_flight), 64'd1);
               check("ack_port", {62'd0, a_ack, b_ack}, exp_port ? 64'd1 : 64'd2);
               if (in_flight) begin
                  if (cur.re && !cur_abort) begin
                     if (exp_port) ref_b_rdata = exp_rdata;
                     else          ref_a_rdata = exp_rdata;
                  end
                  if (cur_abort) check("abort_latency", 64'(cyc - start_cyc), 64'(TIMEOUT + 2));
                  ref_last = exp_port;
                  ack_log.push_back(b_ack);
                  in_flight = 0;
                  if (cur_abort) ref_err = 1;
                  txn_no++;
                  $display("txn %0d: port %s %s addr=0x%04h wdata=0x%02h a_rdata=0x%02h b_rdata=0x%02h%s",
                           txn_no, b_ack ? "B" : "A", cur.re ? "RD" : "WR", cur.addr, cur.wdata,
                           a_rdata, b_rdata, cur_abort ? " (aborted)" : "");
               end
            end
            check("rdata", {48'd0, a_rdata, b_rdata}, {48'd0, ref_a_rdata, ref_b_rdata});
            prev_a = a_req; prev_b = b_req; prev_start = drv_start;
         end
         cyc++;
      end
   end

   // Issue one request on a port and wait for its ack; leaves req high one cycle past the ack.
   task automatic access(input bit port, input logic re, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int lat);
      txn_t t;
      bit   got = 0;
      t.re = re; t.addr = addr; t.wdata = wd;
      lat_cfg = lat;
      if (port) begin
         q_b.push_back(t); b_re = re; b_addr = addr; b_wdata = wd; b_req = 1'b1;
      end else begin
         q_a.push_back(t); a_re = re; a_addr = addr; a_wdata = wd; a_req = 1'b1;
      end
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         got = port ? b_ack : a_ack;
      end
      check(port ? "b_ack_seen" : "a_ack_seen", 64'(got), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic random_port(input bit port, input int n);
      int gap;
      for (int i = 0; i < n; i++) begin
         access(port, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 6));
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            if (port) b_req = 1'b0; else a_req = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
         end
      end
      if (port) b_req = 1'b0; else a_req = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset = 1'b1;
      a_req = 0; a_re = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_re = 0; b_addr = '0; b_wdata = '0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {58'd0, busy, drv_start, a_ack, b_ack, timeout_err, drv_re}, 64'd0);
      check("reset_data", {27'd0, drv_address, drv_data_write, a_rdata, b_rdata}, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // single A write, then single B read of the preset 0xC3 location
      access(0, 1'b0, 13'h0123, 8'h5A, 10); a_req = 0;
      repeat (2) begin @(posedge clk); #1; end
      access(1, 1'b1, 13'h1FFF, 8'h00, 10); b_req = 0;
      check("b_read_c3", 64'(b_rdata), 64'hC3);

      // both ports contending continuously: strict alternation starting with A
      ack_log.delete();
      fork
         begin for (int i = 0; i < 3; i++) access(0, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)), 8'($urandom), 3); a_req = 0; end
         begin for (int i = 0; i < 3; i++) access(1, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)), 8'($urandom), 3); b_req = 0; end
      join
      check("alt_count", 64'(ack_log.size()), 64'd6);
      for (int i = 0; i < ack_log.size() && i < 6; i++) check("alt_order", 64'(ack_log[i]), 64'(i % 2));

      // randomized mixed traffic on a small address window
      fork
         random_port(0, 12);
         random_port(1, 12);
      join

      // requester violates hold: a_addr toggles after grant, latched address must persist
      fork
         begin access(0, 1'b0, 13'h0AAA, 8'h3C, 5); a_req = 0; end
         begin
            seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = drv_start; end
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               if (a_ack) break;
               @(posedge clk); #1 a_addr = 13'($urandom);
            end
         end
      join

      // stuck driver: abort, sticky error, then normal service resumes
      stuck = 1'b1;
      access(1, 1'b0, 13'h0010, 8'hEE, 5); b_req = 0;
      stuck = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      access(0, 1'b1, 13'h0010, 8'h00, 4); a_req = 0;

      // reset during WAIT_DONE
      lat_cfg = 10;
      begin
         txn_t t;
         t.re = 1'b1; t.addr = 13'h0005; t.wdata = '0;
         q_a.push_back(t);
      end
      a_re = 1'b1; a_addr = 13'h0005; a_wdata = '0; a_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = drv_start; end
      check("rst_test_start", 64'(seen), 64'd1);
      repeat (3) @(negedge clk);
      check("rst_test_busy_before", 64'(busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_outputs", {59'd0, busy, drv_start, a_ack, b_ack, timeout_err}, 64'd0);
      a_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      ack_log.delete();
      fork
         begin access(0, 1'b1, 13'h0123, 8'h00, 2); a_req = 0; end
         begin access(1, 1'b1, 13'h0124, 8'h00, 2); b_req = 0; end
      join
      check("post_rst_count", 64'(ack_log.size()), 64'd2);
      if (ack_log.size() > 0) check("post_rst_first_A", 64'(ack_log[0]), 64'd0);

      repeat (5) begin @(posedge clk); #1; end
      check("end_idle", {61'd0, busy, in_flight, 1'b0}, 64'd0);
      check("end_queues", 64'(q_a.size() + q_b.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin arbiter in front of one sram_driver instance (13-bit address, 8-bit data).
- Lets the serial command engine (port A) and a background scan/test engine (port B) share the SRAM.
- Sequences each access as one driver start pulse, then waits for the driver's ready to fall and rise again.
- Returns read data and a one-cycle ack to the winning requester.

Parameters:
- ADDR_W, 13, address width.
- DATA_W, 8, data width.
- TIMEOUT, 255, max cycles in WAIT_BUSY or WAIT_DONE before abort; counter is 8 bits wide.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  port A request; a_re/a_addr/a_wdata held stable until a_ack
- a_re  in  1  1=read, 0=write
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  DATA_W  read data for A, valid when a_ack=1, held until the next A read completes
- b_req, b_re, b_addr, b_wdata, b_ack, b_rdata  same meanings for port B
- drv_ready  in  1  sram_driver ready
- drv_start  out  1  sram_driver start
- drv_re  out  1  sram_driver re
- drv_address  out  ADDR_W  sram_driver address
- drv_data_write  out  DATA_W  sram_driver data_write
- drv_data_read  in  DATA_W  sram_driver data_read
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on abort, cleared only by reset

Behaviour:
- Reset values (asynchronous): state=IDLE; last_grant=B, so A wins the first tie; all other outputs and internal registers 0.
- IDLE:
  - Arbitrates only when drv_ready=1 and at least one req=1.
  - Only one requesting: that port is granted.
  - Both requesting: the port not equal to last_grant is granted.
  - On grant: latch the granted port's re/addr/wdata into drv_re/drv_address/drv_data_write; record grant; go to ISSUE.
  - Request seen at edge N gives drv_start=1 during cycle N+1.
- ISSUE: drv_start=1 for exactly one cycle; clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for drv_ready=0, then go to WAIT_DONE and clear the counter.
  - Otherwise increment the counter; at counter==TIMEOUT go to ABORT.
- WAIT_DONE:
  - Wait for drv_ready=1; then capture drv_data_read into the granted port's rdata (read only; writes leave rdata unchanged) and go to RESP.
  - Same timeout rule as WAIT_BUSY.
- RESP:
  - Pulse granted port's ack for one cycle.
  - Set last_grant to the granted port; go to IDLE.
  - Back-to-back requests therefore cost at least 1 IDLE cycle between accesses.
- ABORT:
  - Set timeout_err; pulse granted ack (rdata unchanged); update last_grant; go to IDLE.
- drv_re, drv_address and drv_data_write are held constant from grant until the return to IDLE.
- drv_start is never high outside ISSUE.
- A req dropped mid-transaction is a protocol violation: the transaction still completes and ack is still pulsed.
- A req asserted while busy is serviced after the current transaction. The ungranted port always wins the next tie, so neither port starves.
- Reset asserted mid-transaction:
  - Immediately forces IDLE.
  - drv_start=0; no ack is generated.
  - The driver is reset by the same signal.

Test Plan:
- Single A write: a_req=1, a_re=0, a_addr=0x0123, a_wdata=0x5A, driver model busy 10 cycles -> one drv_start pulse one cycle after grant, drv_address=0x0123, drv_data_write=0x5A, exactly one a_ack, b_ack never set.
- Single B read: model returns 0xC3 at addr 0x1FFF -> b_rdata=0xC3 on the b_ack cycle, drv_re=1 throughout, a_rdata unchanged.
- Simultaneous: a_req and b_req both high from reset, each reissued immediately after ack, 6 transactions -> grant order A,B,A,B,A,B.
- Driver stuck: model never drops ready -> abort after TIMEOUT+1 cycles in WAIT_BUSY, timeout_err=1, ack pulsed, arbiter returns to IDLE and serves the next request normally.
- Reset mid-access: assert reset during WAIT_DONE -> busy=0, drv_start=0 and all acks 0 on the same edge; timeout_err=0; after release, A wins the first tie.
- Data stability: randomly toggle a_addr after grant -> drv_address stays at the latched value until RESP completes.
